alarm_clock_core: RTL and testbench

//  Parametrised timekeeping + alarm core for the Lab2 clock, successor to the fixed sec/min/hrs
//  top level. Adds a day-of-week counter, per-day alarm mask, snooze and auto-timeout ring FSM.

---
 rtl/alarm_clock_core_if.sv | 30 +++
 rtl/alarm_clock_core.sv | 168 ++++++++++++++++
 tb/tb_alarm_clock_core.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_clock_core_if.sv
// Bundles the control inputs and display/buzzer outputs of alarm_clock_core.
//   master: drives the set/advance/arm/snooze controls, observes time, alarm, Buzz and Snoozing.
//   slave : the core side; reads the controls and drives the registered outputs.
interface alarm_clock_core_if;
  logic       Timeset;
  logic       Alarmset;
  logic       Minadv;
  logic       Hrsadv;
  logic       Dayadv;
  logic       Alarmon;
  logic       Snooze;
  logic [6:0] TSec;
  logic [6:0] TMin;
  logic [6:0] THrs;
  logic [2:0] TDay;
  logic [6:0] AMin;
  logic [6:0] AHrs;
  logic       Buzz;
  logic       Snoozing;

  modport master (
    output Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon, Snooze,
    input  TSec, TMin, THrs, TDay, AMin, AHrs, Buzz, Snoozing
  );

  modport slave (
    input  Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Alarmon, Snooze,
    output TSec, TMin, THrs, TDay, AMin, AHrs, Buzz, Snoozing
  );
endinterface

// File: rtl/alarm_clock_core.sv
// Timekeeping and alarm core: sec/min/hrs/day counters, alarm registers, per-day alarm mask,
// and a ring/snooze FSM with automatic ring timeout.
//   Pulse : clock, one cycle per second
//   Reset : asynchronous active-high reset
//   bus   : alarm_clock_core_if.slave carrying the set/advance/arm/snooze controls and the
//           registered time, alarm, Buzz and Snoozing outputs
module alarm_clock_core #(
  parameter int unsigned   NS       = 60,
  parameter int unsigned   NH       = 24,
  parameter int unsigned   ND       = 7,
  parameter logic [ND-1:0] DAY_MASK = ND'(7'h1F),
  parameter int unsigned   SNOOZE_M = 9,
  parameter int unsigned   RING_S   = 60
) (
  input logic               Pulse,
  input logic               Reset,
  alarm_clock_core_if.slave bus
);

  localparam int unsigned RingW = $clog2(RING_S + 1);
  localparam int unsigned SnzW  = $clog2(SNOOZE_M * NS + 1);

  localparam logic [6:0]       SecLast  = 7'(NS - 1);
  localparam logic [6:0]       HrsLast  = 7'(NH - 1);
  localparam logic [2:0]       DayLast  = 3'(ND - 1);
  localparam logic [RingW-1:0] RingLast = RingW'(RING_S - 1);
  localparam logic [SnzW-1:0]  SnzLast  = SnzW'(SNOOZE_M * NS - 1);
  // Widened so the mask can be indexed by the full 3-bit day count for any ND.
  localparam logic [7:0]       MaskExt  = 8'(DAY_MASK);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

  state_e           state_q, state_d;
  logic [6:0]       tsec_q, tsec_d, tmin_q, tmin_d, thrs_q, thrs_d;
  logic [2:0]       tday_q, tday_d;
  logic [6:0]       amin_q, amin_d, ahrs_q, ahrs_d;
  logic [RingW-1:0] ring_ct_q, ring_ct_d;
  logic [SnzW-1:0]  snz_ct_q, snz_ct_d;
  logic             snz_prev_q;
  logic             match;
  logic             snz_rise;

  function automatic logic [6:0] inc7(input logic [6:0] v, input logic [6:0] last);
    return (v == last) ? 7'd0 : v + 7'd1;
  endfunction

  function automatic logic [2:0] inc3(input logic [2:0] v, input logic [2:0] last);
    return (v == last) ? 3'd0 : v + 3'd1;
  endfunction

  // Time and alarm registers
  always_comb begin
    tsec_d = tsec_q;
    tmin_d = tmin_q;
    thrs_d = thrs_q;
    tday_d = tday_q;
    amin_d = amin_q;
    ahrs_d = ahrs_q;
    if (bus.Timeset) begin
      // Manual advances wrap independently with no carry; seconds freeze.
      if (bus.Minadv) tmin_d = inc7(tmin_q, SecLast);
      if (bus.Hrsadv) thrs_d = inc7(thrs_q, HrsLast);
      if (bus.Dayadv) tday_d = inc3(tday_q, DayLast);
    end else begin
      tsec_d = inc7(tsec_q, SecLast);
      if (tsec_q == SecLast) begin
        tmin_d = inc7(tmin_q, SecLast);
        if (tmin_q == SecLast) begin
          thrs_d = inc7(thrs_q, HrsLast);
          if (thrs_q == HrsLast) tday_d = inc3(tday_q, DayLast);
        end
      end
      if (bus.Alarmset) begin
        if (bus.Minadv) amin_d = inc7(amin_q, SecLast);
        if (bus.Hrsadv) ahrs_d = inc7(ahrs_q, HrsLast);
      end
    end
  end

  assign match = bus.Alarmon && !bus.Timeset && !bus.Alarmset && (tsec_q == 7'd0) &&
                 (tmin_q == amin_q) && (thrs_q == ahrs_q) && MaskExt[tday_q];

  // A held Snooze only acts on its first cycle.
  assign snz_rise = bus.Snooze && !snz_prev_q;

  // Ring/snooze FSM
  always_comb begin
    state_d   = state_q;
    ring_ct_d = ring_ct_q;
    snz_ct_d  = snz_ct_q;
    if (!bus.Alarmon) begin
      state_d   = StIdle;
      ring_ct_d = '0;
      snz_ct_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (match) begin
            state_d   = StRing;
            ring_ct_d = '0;
          end
        end
        StRing: begin
          // Snooze beats the timeout when both land on the same cycle.
          if (snz_rise) begin
            state_d  = StSnooze;
            snz_ct_d = '0;
          end else if (ring_ct_q == RingLast) begin
            state_d   = StIdle;
            ring_ct_d = '0;
          end else begin
            ring_ct_d = ring_ct_q + 1'b1;
          end
        end
        StSnooze: begin
          if (snz_ct_q == SnzLast) begin
            state_d   = StRing;
            ring_ct_d = '0;
            snz_ct_d  = '0;
          end else begin
            snz_ct_d = snz_ct_q + 1'b1;
          end
        end
        default: begin
          state_d   = StIdle;
          ring_ct_d = '0;
          snz_ct_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Pulse or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      tsec_q     <= '0;
      tmin_q     <= '0;
      thrs_q     <= '0;
      tday_q     <= '0;
      amin_q     <= '0;
      ahrs_q     <= '0;
      ring_ct_q  <= '0;
      snz_ct_q   <= '0;
      snz_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tsec_q     <= tsec_d;
      tmin_q     <= tmin_d;
      thrs_q     <= thrs_d;
      tday_q     <= tday_d;
      amin_q     <= amin_d;
      ahrs_q     <= ahrs_d;
      ring_ct_q  <= ring_ct_d;
      snz_ct_q   <= snz_ct_d;
      snz_prev_q <= bus.Snooze;
    end
  end

  assign bus.TSec     = tsec_q;
  assign bus.TMin     = tmin_q;
  assign bus.THrs     = thrs_q;
  assign bus.TDay     = tday_q;
  assign bus.AMin     = amin_q;
  assign bus.AHrs     = ahrs_q;
  assign bus.Buzz     = (state_q == StRing);
  assign bus.Snoozing = (state_q == StSnooze);

endmodule

// File: tb/tb_alarm_clock_core.sv
// Self-checking bench for alarm_clock_core with default parameters.
module tb_alarm_clock_core;

  logic Pulse = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  alarm_clock_core_if u_if ();

  alarm_clock_core u_dut (
    .Pulse (Pulse),
    .Reset (Reset),
    .bus   (u_if)
  );

  always #5 Pulse = ~Pulse;

  typedef struct packed {
    logic [6:0] sec;
    logic [6:0] min;
    logic [6:0] hrs;
    logic [2:0] day;
    logic [6:0] amin;
    logic [6:0] ahrs;
    logic       buzz;
    logic       snz;
  } obs_t;

  typedef struct packed {
    logic ts, as_, mi, hi, di, on, sz;
    obs_t exp;
  } vec_t;

  vec_t vecs[10];
  obs_t sb_q[$];

  function automatic obs_t sample();
    obs_t o;
    o = '{u_if.TSec, u_if.TMin, u_if.THrs, u_if.TDay, u_if.AMin, u_if.AHrs, u_if.Buzz,
          u_if.Snoozing};
    return o;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Pulse);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic ts, as_, mi, hi, di, on, sz);
    u_if.Timeset  = ts;
    u_if.Alarmset = as_;
    u_if.Minadv   = mi;
    u_if.Hrsadv   = hi;
    u_if.Dayadv   = di;
    u_if.Alarmon  = on;
    u_if.Snooze   = sz;
  endtask

  // Counts consecutive observed cycles with Buzz (sel=0) or Snoozing (sel=1) high.
  task automatic count_high(input bit sel, output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if ((sel ? u_if.Snoozing : u_if.Buzz) !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  task automatic wait_buzz(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (u_if.Buzz === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Timeset with Minadv until minutes read 31 (stimulus steering only).
  task automatic set_min_31();
    set_in(1, 0, 1, 0, 0, u_if.Alarmon, 0);
    for (int i = 0; i < 100; i++) begin
      if (u_if.TMin == 7'd31) break;
      tick();
    end
    set_in(0, 0, 0, 0, 0, u_if.Alarmon, 0);
  endtask

  initial begin
    int   n;
    bit   ok;
    bit   rang;
    obs_t e;
    obs_t a;

    //            ts as mi hi di on sz   sec  min  hrs day amin ahrs bz sn
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '{7'd1, 7'd0, 7'd0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0}};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '{7'd2, 7'd0, 7'd0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0}};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '{7'd2, 7'd1, 7'd0, 3'd0, 7'd0, 7'd0, 1'b0, 1'b0}};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '{7'd2, 7'd2, 7'd1, 3'd1, 7'd0, 7'd0, 1'b0, 1'b0}};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '{7'd2, 7'd3, 7'd1, 3'd1, 7'd0, 7'd0, 1'b0, 1'b0}};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '{7'd3, 7'd3, 7'd1, 3'd1, 7'd1, 7'd1, 1'b0, 1'b0}};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '{7'd4, 7'd3, 7'd1, 3'd1, 7'd1, 7'd2, 1'b0, 1'b0}};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '{7'd5, 7'd3, 7'd1, 3'd1, 7'd1, 7'd2, 1'b0, 1'b0}};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '{7'd6, 7'd3, 7'd1, 3'd1, 7'd1, 7'd2, 1'b0, 1'b0}};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '{7'd7, 7'd3, 7'd1, 3'd1, 7'd1, 7'd2, 1'b0, 1'b0}};

    Reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick(2);
    Reset = 1'b0;
    chk("reset_state", 64'(sample()), 64'(obs_t'('0)));

    // Table vectors through the scoreboard
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].ts, vecs[i].as_, vecs[i].mi, vecs[i].hi, vecs[i].di, vecs[i].on, vecs[i].sz);
      sb_q.push_back(vecs[i].exp);
      tick();
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd0, 64'd1);
      end else begin
        e = sb_q.pop_front();
        a = sample();
        chk($sformatf("vec%0d", i), 64'(a), 64'(e));
      end
    end

    // Minute wrap under Timeset: no carry into hours, seconds frozen at 7
    set_in(1, 0, 1, 0, 0, 0, 0);
    tick(57);
    chk("ts_min_wrap", {u_if.TSec, u_if.TMin, u_if.THrs}, {7'd7, 7'd0, 7'd1});
    tick(61);
    chk("ts_min_61", {u_if.TSec, u_if.TMin, u_if.THrs}, {7'd7, 7'd1, 7'd1});
    set_in(1, 0, 0, 0, 1, 0, 0);
    tick(7);
    chk("ts_day_7", u_if.TDay, 3'd1);

    // Build 23:59:59 and check the day carry
    set_in(1, 0, 0, 1, 0, 0, 0);
    tick(22);
    set_in(1, 0, 1, 0, 0, 0, 0);
    tick(58);
    set_in(0, 0, 0, 0, 0, 0, 0);
    tick(52);
    chk("t235959", {u_if.THrs, u_if.TMin, u_if.TSec, u_if.TDay}, {7'd23, 7'd59, 7'd59, 3'd1});
    tick();
    chk("day_carry", {u_if.THrs, u_if.TMin, u_if.TSec, u_if.TDay}, {7'd0, 7'd0, 7'd0, 3'd2});
    set_in(1, 0, 0, 0, 1, 0, 0);
    tick(5);
    chk("day_wrap", u_if.TDay, 3'd0);

    // Alarm 06:30 on day 0
    set_in(0, 1, 1, 0, 0, 0, 0);
    tick(29);
    set_in(0, 1, 0, 1, 0, 0, 0);
    tick(4);
    chk("alarm_set", {u_if.AHrs, u_if.AMin, u_if.TSec}, {7'd6, 7'd30, 7'd33});
    set_in(1, 0, 0, 1, 0, 0, 0);
    tick(6);
    set_in(1, 0, 1, 0, 0, 0, 0);
    tick(29);
    set_in(0, 0, 0, 0, 0, 1, 0);
    tick(26);
    chk("t062959", {u_if.THrs, u_if.TMin, u_if.TSec, 6'(u_if.Buzz)}, {7'd6, 7'd29, 7'd59, 6'd0});
    tick();
    chk("buzz_at_0630", {u_if.TSec, 6'(u_if.Buzz)}, {7'd0, 6'd0});
    tick();
    chk("buzz_at_063001", {u_if.TSec, 6'(u_if.Buzz)}, {7'd1, 6'd1});
    count_high(1'b0, n);
    chk("ring_len", n, 60);

    // Snooze at ring cycle 5, then a fresh full ring
    set_in(0, 1, 1, 0, 0, 1, 0);
    tick(2);
    set_in(0, 0, 0, 0, 0, 1, 0);
    chk("alarm_0632", u_if.AMin, 7'd32);
    wait_buzz(200, ok);
    chk("ring2_start", ok, 1'b1);
    tick(4);
    u_if.Snooze = 1'b1;
    tick();
    u_if.Snooze = 1'b0;
    chk("snooze_enter", {u_if.Snoozing, u_if.Buzz}, 2'b10);
    count_high(1'b1, n);
    chk("snooze_len", n, 540);
    count_high(1'b0, n);
    chk("ring_after_snooze", n, 60);

    // Day 5 is masked off: no ring
    set_in(1, 0, 0, 0, 1, 1, 0);
    tick(5);
    chk("day5", u_if.TDay, 3'd5);
    set_min_31();
    rang = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (u_if.Buzz === 1'b1) rang = 1'b1;
    end
    chk("mask_day5", rang, 1'b0);

    // Alarmon dropped mid-ring -> idle on next edge
    set_in(1, 0, 0, 0, 1, 1, 0);
    tick(2);
    chk("day0_again", u_if.TDay, 3'd0);
    set_min_31();
    wait_buzz(200, ok);
    chk("ring3_start", ok, 1'b1);
    tick(3);
    u_if.Alarmon = 1'b0;
    tick();
    chk("alarmon_off", u_if.Buzz, 1'b0);

    // Async reset while snoozing
    u_if.Alarmon = 1'b1;
    set_min_31();
    wait_buzz(200, ok);
    chk("ring4_start", ok, 1'b1);
    u_if.Snooze = 1'b1;
    tick();
    u_if.Snooze = 1'b0;
    chk("snooze4", u_if.Snoozing, 1'b1);
    tick(10);
    #2;
    Reset = 1'b1;
    u_if.Alarmon = 1'b0;
    #1;
    chk("async_reset", 64'(sample()), 64'(obs_t'('0)));
    tick();
    Reset = 1'b0;

    // Timeset wins over Alarmset
    set_in(1, 1, 1, 0, 0, 0, 0);
    tick(3);
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("ts_over_as", {u_if.TMin, u_if.AMin, u_if.TSec}, {7'd3, 7'd0, 7'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
